led_decoder_seq: RTL and testbench
==================================

Name: led_decoder_seq

Overview:
- Registered, parametrised successor to the 3-to-8 active-low LED decoder with 3-pin enable.
- Decodes a SEL_W-bit select into 2**SEL_W active-low LED lines.
- Adds four run-time modes: direct, latched, auto-scan, blink.
- Sits between the switch/enable inputs and the board LED bank; all outputs are driven from flops.

Parameters:
- SEL_W, 3, select width; output count OUT_N = 2**SEL_W (localparam, not overridable).
- DIV_W, 8, width of the prescaler divide input.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  3  G1/G2A_n/G2B_n enable pins; active only when enable == 3'b100.
- switch  input  SEL_W  line select.
- mode  input  2  0 DIRECT, 1 LATCH, 2 SCAN, 3 BLINK.
- div  input  DIV_W  prescaler terminal count; tick period is div+1 cycles.
- led  output  OUT_N  active-low LED lines (0 = lit).

Behaviour:
- en = (enable == 3'b100). Any other enable code is inactive.
- Reset (rst low, async): led = all ones, prescaler cnt = 0, scan idx = 0, blink phase = 1 (on), latch register = all ones, mode_q = 0.
- All modes have 1-cycle latency: led is updated on the clk edge following input sampling.
- Decode value: dec(x) = ~(1 << x), width OUT_N. Exactly one bit is low.
- Prescaler:
  - cnt counts 0..div; tick = en && (cnt == div).
  - On tick, cnt wraps to 0. div = 0 gives a tick every cycle.
  - cnt advances only in SCAN or BLINK with en high; otherwise it holds.
  - If div is lowered below the current cnt, cnt wraps to 0 on the next cycle and generates no tick.
- Mode change: mode_q registers mode. When mode != mode_q in a cycle, that cycle clears cnt and idx and sets phase = 1. led is still computed from the new mode in that cycle.
- DIRECT: led <= en ? dec(switch) : all ones.
- LATCH:
  - en high: led <= dec(switch) and latch register <= dec(switch).
  - en low: led <= latch register (holds the last enabled value).
  - Immediately after reset with no enabled cycle yet: all ones.
- SCAN:
  - en high: led <= dec(idx); on tick, idx <= idx + 1, wrapping from OUT_N-1 to 0.
  - en low: led <= all ones; idx and cnt hold. switch is ignored.
- BLINK:
  - en high: on tick, phase toggles; led <= phase ? dec(switch) : all ones, using the post-toggle phase.
  - en low: led <= all ones; phase and cnt hold.
- Simultaneous events: a mode change takes priority over a tick in the same cycle; reset overrides everything.
- Reset mid-scan or mid-blink: led goes high (all ones) asynchronously; scanning resumes from idx 0 after rst returns high.

Decomposition:
- Package led_decoder_pkg:
  - mode enum (MODE_DIRECT, MODE_LATCH, MODE_SCAN, MODE_BLINK).
  - EN_ACTIVE = 3'b100.
  - Function onehot_n(sel) returning the active-low decode.
- Sub-module led_prescaler: DIV_W counter with inputs run and clr, output tick.
- Top level: mode register, idx/phase/latch flops, output mux register.

Test Plan:
- Reset with enable=3'b100, mode=0, switch=5 → led=8'hFF while rst low; first edge after release gives led=8'hDF.
- DIRECT, sweep switch 0..7 with en active → led = FE, FD, FB, F7, EF, DF, BF, 7F, each 1 cycle late. Any enable != 3'b100 (e.g. 3'b101, 3'b000) → FF.
- LATCH, switch=2 with en active, then enable=3'b000 and switch=6 → led stays 8'hFB; re-enable → 8'hBF.
- SCAN, div=2 → led walks FE, FD, ..., 7F, FE, each value held 3 cycles. Drop en for 4 cycles mid-walk at FB → FF during the gap, then resumes at FB.
- BLINK, div=0, switch=3 → led alternates F7/FF every cycle. div=3 → alternates every 4 cycles. Switch mode to DIRECT mid-off-phase → next led = F7.
- Async reset asserted between clock edges during SCAN → led=FF immediately; after release, scan restarts at FE.

Source files
------------

// File: rtl/led_decoder_pkg.sv
// Shared types and helpers for the registered LED decoder.
package led_decoder_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_LATCH  = 2'd1,
        MODE_SCAN   = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    localparam logic [2:0] EN_ACTIVE = 3'b100;
    localparam int         MAX_OUT   = 256;

    // Active-low one-hot decode; callers keep the low OUT_N bits.
    function automatic logic [MAX_OUT-1:0] onehot_n(input int unsigned sel);
        return ~(MAX_OUT'(1) << sel);
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Programmable tick prescaler: counts 0..div while run is high.
module led_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            if (cnt_q == div) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else if (cnt_q > div) begin
                // div was lowered under the count: resync without a tick
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_decoder_seq.sv
// Registered active-low LED decoder with direct, latch, scan and blink modes.
module led_decoder_seq
    import led_decoder_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int DIV_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            enable,
    input  logic [SEL_W-1:0]      switch,
    input  logic [1:0]            mode,
    input  logic [DIV_W-1:0]      div,
    output logic [(2**SEL_W)-1:0] led
);

    localparam int OUT_N = 2**SEL_W;

    mode_e            mode_in;
    mode_e            mode_q;
    logic             en;
    logic             mode_chg;
    logic             run;
    logic             tick;
    logic [SEL_W-1:0] idx_q;
    logic [SEL_W-1:0] idx_d;
    logic             phase_q;
    logic             phase_d;
    logic [OUT_N-1:0] latch_q;
    logic [OUT_N-1:0] latch_d;
    logic [OUT_N-1:0] led_q;
    logic [OUT_N-1:0] led_d;
    logic [MAX_OUT-1:0] dec_sw_full;
    logic [MAX_OUT-1:0] dec_idx_full;
    logic [OUT_N-1:0] dec_sw;
    logic [OUT_N-1:0] dec_idx;

    led_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst),
        .run   (run),
        .clr   (mode_chg),
        .div   (div),
        .tick  (tick)
    );

    always_comb begin
        mode_in  = mode_e'(mode);
        en       = (enable == EN_ACTIVE);
        mode_chg = (mode_in != mode_q);
        run      = en && ((mode_in == MODE_SCAN) || (mode_in == MODE_BLINK));

        idx_d = idx_q;
        if (mode_chg) begin
            idx_d = '0;
        end else if (tick && (mode_in == MODE_SCAN)) begin
            idx_d = idx_q + 1'b1;
        end

        phase_d = phase_q;
        if (mode_chg) begin
            phase_d = 1'b1;
        end else if (tick && (mode_in == MODE_BLINK)) begin
            phase_d = ~phase_q;
        end

        dec_sw_full  = onehot_n(32'(switch));
        dec_idx_full = onehot_n(32'(idx_d));
        dec_sw       = dec_sw_full[OUT_N-1:0];
        dec_idx      = dec_idx_full[OUT_N-1:0];

        latch_d = latch_q;
        if ((mode_in == MODE_LATCH) && en) begin
            latch_d = dec_sw;
        end

        // Scan and blink show the post-update index/phase so each step lasts div+1 cycles
        led_d = '1;
        case (mode_in)
            MODE_DIRECT: led_d = en ? dec_sw : '1;
            MODE_LATCH:  led_d = en ? dec_sw : latch_q;
            MODE_SCAN:   led_d = en ? dec_idx : '1;
            MODE_BLINK:  led_d = (en && phase_d) ? dec_sw : '1;
            default:     led_d = '1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q  <= MODE_DIRECT;
            idx_q   <= '0;
            phase_q <= 1'b1;
            latch_q <= '1;
            led_q   <= '1;
        end else begin
            mode_q  <= mode_in;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            latch_q <= latch_d;
            led_q   <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_decoder_seq.sv
// Directed self-checking bench for led_decoder_seq.
module tb_led_decoder_seq;

    logic       clk;
    logic       rst;
    logic [2:0] enable;
    logic [2:0] switch;
    logic [1:0] mode;
    logic [7:0] div;
    logic [7:0] led;

    int total;
    int bad;

    led_decoder_seq #(
        .SEL_W (3),
        .DIV_W (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .switch (switch),
        .mode   (mode),
        .div    (div),
        .led    (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] exp);
        total++;
        assert (led === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, led, exp);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] exp);
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    task automatic run_n(input string tag, input logic [7:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            step(tag, exp);
        end
    endtask

    logic [7:0] exp_dir [8];

    initial begin
        total = 0;
        bad   = 0;
        exp_dir = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

        rst    = 1'b0;
        enable = 3'b100;
        mode   = 2'd0;
        switch = 3'd5;
        div    = 8'd0;

        #12;
        check("rst_low", 8'hFF);
        @(posedge clk);
        #1;
        check("rst_low_edge", 8'hFF);
        #3 rst = 1'b1;
        step("rst_release", 8'hDF);

        for (int i = 0; i < 8; i++) begin
            switch = 3'(i);
            step("direct_sweep", exp_dir[i]);
        end
        enable = 3'b101;
        step("direct_en101", 8'hFF);
        enable = 3'b000;
        step("direct_en000", 8'hFF);
        enable = 3'b100;

        mode   = 2'd1;
        switch = 3'd2;
        step("latch_load", 8'hFB);
        enable = 3'b000;
        switch = 3'd6;
        run_n("latch_hold", 8'hFB, 2);
        enable = 3'b100;
        step("latch_reenable", 8'hBF);

        mode = 2'd2;
        div  = 8'd2;
        run_n("scan_fe", 8'hFE, 3);
        run_n("scan_fd", 8'hFD, 3);
        run_n("scan_fb", 8'hFB, 2);
        enable = 3'b000;
        switch = 3'd1;
        run_n("scan_gap", 8'hFF, 4);
        enable = 3'b100;
        run_n("scan_resume_fb", 8'hFB, 1);
        run_n("scan_f7", 8'hF7, 3);
        run_n("scan_ef", 8'hEF, 3);
        run_n("scan_df", 8'hDF, 3);
        run_n("scan_bf", 8'hBF, 3);
        run_n("scan_7f", 8'h7F, 3);
        run_n("scan_wrap_fe", 8'hFE, 3);

        mode   = 2'd3;
        div    = 8'd0;
        switch = 3'd3;
        for (int i = 0; i < 3; i++) begin
            step("blink_d0_on", 8'hF7);
            step("blink_d0_off", 8'hFF);
        end

        mode = 2'd0;
        step("direct_gap", 8'hF7);
        mode = 2'd3;
        div  = 8'd3;
        run_n("blink_d3_on", 8'hF7, 4);
        run_n("blink_d3_off", 8'hFF, 2);
        mode = 2'd0;
        step("blink_to_direct", 8'hF7);

        mode = 2'd2;
        div  = 8'd2;
        run_n("scan_pre_rst", 8'hFE, 3);
        step("scan_pre_rst_fd", 8'hFD);
        #3 rst = 1'b0;
        #1;
        check("async_rst", 8'hFF);
        @(posedge clk);
        #1;
        check("async_rst_edge", 8'hFF);
        #3 rst = 1'b1;
        run_n("scan_restart_fe", 8'hFE, 3);
        step("scan_restart_fd", 8'hFD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
